// File: rtl/ucore_call_seq.sv
// Microcode sequencer: steps a micro-PC through a ROM with jump, call/return
// on a small LIFO stack, an OUT handshake, and sticky HALT/ERROR states.
module ucore_call_seq #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [2:0]        rom_op,
    input  logic [ADDR_W-1:0] rom_tgt,
    input  logic              enable,
    output logic [ADDR_W-1:0] upc,
    output logic              valid,
    output logic [3:0]        depth,
    output logic              halted,
    output logic              err
);
    localparam int SP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT, S_ERR} state_t;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_OUT  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   upc_q, upc_d;
    logic [3:0]          depth_q, depth_d;
    logic                push;
    logic [ADDR_W-1:0]   stack_q [DEPTH];
    logic [SP_W-1:0]     sp_wr, sp_rd;
    logic [ADDR_W-1:0]   upc_inc;

    // Write slot is the current depth; the top entry sits one below it.
    assign sp_wr   = depth_q[SP_W-1:0];
    assign sp_rd   = sp_wr - 1'b1;
    assign upc_inc = upc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= S_RUN;
            upc_q   <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aresetn && push)
            stack_q[sp_wr] <= upc_inc;
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        depth_d = depth_q;
        push    = 1'b0;
        case (state_q)
            S_RUN: begin
                case (rom_op)
                    OP_NEXT: upc_d = upc_inc;
                    OP_JUMP: upc_d = rom_tgt;
                    OP_CALL: begin
                        if (depth_q == 4'(DEPTH)) begin
                            state_d = S_ERR;
                        end else begin
                            push    = 1'b1;
                            depth_d = depth_q + 4'd1;
                            upc_d   = rom_tgt;
                        end
                    end
                    OP_RET: begin
                        if (depth_q == 4'd0) begin
                            state_d = S_ERR;
                        end else begin
                            upc_d   = stack_q[sp_rd];
                            depth_d = depth_q - 4'd1;
                        end
                    end
                    OP_OUT:  state_d = S_WAIT;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_ERR;
                endcase
            end
            S_WAIT: begin
                if (enable) begin
                    upc_d   = upc_inc;
                    state_d = S_RUN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        upc    = upc_q;
        depth  = depth_q;
        valid  = (state_q == S_WAIT);
        halted = (state_q == S_HALT);
        err    = (state_q == S_ERR);
    end
endmodule

// File: tb/tb_ucore_call_seq.sv
// Directed bench for ucore_call_seq: each step drives one opcode, advances one
// edge and checks the registered outputs against hand-computed values.
module tb_ucore_call_seq;
    logic       clk = 1'b0;
    logic       aresetn;
    logic [2:0] rom_op;
    logic [7:0] rom_tgt;
    logic       enable;
    logic [7:0] upc;
    logic       valid;
    logic [3:0] depth;
    logic       halted;
    logic       err;

    int ncmp  = 0;
    int nfail = 0;

    localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, CAL = 3'd2, RET = 3'd3,
                           OUT = 3'd4, HLT = 3'd5, ILL = 3'd6;

    ucore_call_seq #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .aresetn(aresetn), .rom_op(rom_op), .rom_tgt(rom_tgt),
        .enable(enable), .upc(upc), .valid(valid), .depth(depth),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_upc, input logic [3:0] e_dep,
                           input logic e_vld, input logic e_hlt, input logic e_err);
        chk({tag, ".upc"},    32'(upc),    32'(e_upc));
        chk({tag, ".depth"},  32'(depth),  32'(e_dep));
        chk({tag, ".valid"},  32'(valid),  32'(e_vld));
        chk({tag, ".halted"}, 32'(halted), 32'(e_hlt));
        chk({tag, ".err"},    32'(err),    32'(e_err));
    endtask

    task automatic step(input logic [2:0] op, input logic [7:0] tgt);
        rom_op  = op;
        rom_tgt = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step(NXT, 8'h00);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        enable  = 1'b0;
        rom_op  = NXT;
        rom_tgt = 8'h00;

        // Reset state, with a CALL presented during reset
        rom_op = CAL; rom_tgt = 8'h55;
        @(posedge clk); #1;
        chk_all("reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        aresetn = 1'b1;

        // NEXT,NEXT,JUMP 0x10
        step(NXT, 8'h00); chk("seq0.upc", 32'(upc), 32'h01);
        step(NXT, 8'h00); chk("seq1.upc", 32'(upc), 32'h02);
        step(JMP, 8'h10); chk_all("seq_jump", 8'h10, 4'd0, 1'b0, 1'b0, 1'b0);

        // CALL 0x20 at 0x05, RET
        step(JMP, 8'h05); chk("to05.upc", 32'(upc), 32'h05);
        step(CAL, 8'h20); chk_all("call20", 8'h20, 4'd1, 1'b0, 1'b0, 1'b0);
        step(RET, 8'h99); chk_all("ret06", 8'h06, 4'd0, 1'b0, 1'b0, 1'b0);

        // LIFO order, then RET underflow
        do_reset();
        step(CAL, 8'h30); chk_all("lifo_c1", 8'h30, 4'd1, 1'b0, 1'b0, 1'b0);
        step(CAL, 8'h40); chk_all("lifo_c2", 8'h40, 4'd2, 1'b0, 1'b0, 1'b0);
        step(RET, 8'h00); chk_all("lifo_r1", 8'h31, 4'd1, 1'b0, 1'b0, 1'b0);
        step(RET, 8'h00); chk_all("lifo_r2", 8'h01, 4'd0, 1'b0, 1'b0, 1'b0);
        step(RET, 8'h00); chk_all("underflow", 8'h01, 4'd0, 1'b0, 1'b0, 1'b1);

        // Return with depth 0 directly after reset
        do_reset();
        step(RET, 8'h00); chk_all("ret_at_reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

        // Overflow on fifth CALL; ERROR freezes and ignores ops/enable
        do_reset();
        step(CAL, 8'h10); step(CAL, 8'h20); step(CAL, 8'h30);
        step(CAL, 8'h40); chk_all("nest4", 8'h40, 4'd4, 1'b0, 1'b0, 1'b0);
        step(CAL, 8'h50); chk_all("overflow", 8'h40, 4'd4, 1'b0, 1'b0, 1'b1);
        enable = 1'b1;
        step(OUT, 8'h00); chk_all("err_frozen_out", 8'h40, 4'd4, 1'b0, 1'b0, 1'b1);
        step(JMP, 8'h77); chk_all("err_frozen_jmp", 8'h40, 4'd4, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;

        // OUT at 0x03, enable low for 5 cycles then accept
        do_reset();
        step(JMP, 8'h03);
        step(OUT, 8'h00); chk_all("out_rise", 8'h03, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(JMP, 8'h99);
            chk_all($sformatf("out_hold%0d", i), 8'h03, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        enable = 1'b1;
        step(JMP, 8'h99); chk_all("out_accept", 8'h04, 4'd0, 1'b0, 1'b0, 1'b0);

        // Enable already high at the edge where valid rises does not complete
        step(OUT, 8'h00); chk_all("out_early_en", 8'h04, 4'd0, 1'b1, 1'b0, 1'b0);
        step(NXT, 8'h00); chk_all("out_early_acc", 8'h05, 4'd0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;

        // Reset mid-handshake with enable high
        step(CAL, 8'h08);
        step(OUT, 8'h00); chk_all("mid_wait", 8'h08, 4'd1, 1'b1, 1'b0, 1'b0);
        enable = 1'b1;
        aresetn = 1'b0;
        step(NXT, 8'h00); chk_all("rst_in_wait", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        aresetn = 1'b1;
        enable = 1'b0;
        step(NXT, 8'h00); chk("run_after_rst.upc", 32'(upc), 32'h01);

        // HALT at 0x07 is sticky until reset
        step(JMP, 8'h07);
        step(HLT, 8'h00); chk_all("halt", 8'h07, 4'd0, 1'b0, 1'b1, 1'b0);
        enable = 1'b1;
        step(NXT, 8'h00); step(CAL, 8'h44);
        chk_all("halt_sticky", 8'h07, 4'd0, 1'b0, 1'b1, 1'b0);
        enable = 1'b0;
        do_reset(); chk_all("halt_reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Illegal opcodes
        step(NXT, 8'h00);
        step(ILL, 8'h00); chk_all("illegal6", 8'h01, 4'd0, 1'b0, 1'b0, 1'b1);
        do_reset();
        step(3'd7, 8'h00); chk_all("illegal7", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

        // NEXT wraps from 0xFF
        do_reset();
        step(JMP, 8'hFF); chk("to_ff.upc", 32'(upc), 32'hFF);
        step(NXT, 8'h00); chk_all("wrap", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
